fpu_nor_stage: RTL and testbench
================================

Name: fpu_nor_stage

Overview:
- FPU normalize/round stage. It consumes the EX/NOR pipeline-register outputs and produces the final IEEE-754 single-precision result, with fRd and fregWrite, for the FP writeback register.
- Two internal pipeline stages:
  - N1: leading-zero detect and shift.
  - N2: round, exponent adjust, special cases, output register.
- A valid/ready handshake lets the writeback side stall the stage.

Parameters:
- FRAC_W, 48, width of the incoming unsigned fraction magnitude; binary point sits between bits FRAC_W-2 and FRAC_W-3.
- EXP_W, 8, biased exponent width (bias 127).

Ports:
- clk  input  1  clock
- rst  input  1  reset
- in_valid  input  1  nor* fields hold a live operation
- in_ready  output  1  stage accepts nor* this cycle
- norfracALU  input  48  fraction magnitude; value = frac/2^46, range [0,4)
- norswap  input  1  operand-swap flag; carried for trace only, no effect on the result
- norsign  input  1  result sign for FMUL
- norsignMAX  input  1  result sign for FADD/FSUB
- norFALUop  input  5  5'd0 FADD, 5'd1 FSUB, 5'd2 FMUL; others are no-op
- norexpSUM  input  8  biased exponent for FMUL (ea+eb-127, already wrapped to 8 bits)
- norexpMAX  input  8  biased exponent for FADD/FSUB
- norfregWrite  input  1  write-enable request
- norfRd  input  5  destination FP register
- out_valid  output  1  result valid
- out_ready  input  1  writeback accepts result
- wbresult  output  32  packed float {sign, exp[7:0], mant[22:0]}
- wbfregWrite  output  1  write enable toward the FP regfile
- wbfRd  output  5  destination register
- wbflags  output  3  {overflow, underflow, inexact}

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk, rising edge. On rst, all of the following go to 0, and both stages become empty:
  - out_valid, wbresult, wbfregWrite, wbfRd, wbflags
  - internal N1 registers
- Reset mid-operation: in-flight entries are discarded and never delivered.
- Advance enable: adv = !out_valid | out_ready. in_ready = adv (combinational).
  - When adv=1, N1 loads from the inputs and N2 loads from N1 simultaneously.
  - When adv=0, both stages hold.
  - Bubbles are not collapsed.
- Latency: exactly 2 advancing cycles from accepted input to out_valid.
- N1 register contents: valid, op, sign_sel, exponent base, and shift result.
  - sign_sel = norsign for FMUL, norsignMAX otherwise.
  - Exponent base (10-bit signed) = expSUM for FMUL, expMAX otherwise.
  - If frac[47]=1: shift right by 1, exp+1, and OR the shifted-out bit into sticky.
  - Else: lz = leading zeros of frac[46:0]; shift left by lz; exp-lz.
  - If frac==0: set zero flag.
- N2 rounding: round-to-nearest-even on the normalized value n.
  - Hidden bit is n[46], mantissa is n[45:23], G is n[22], S is |n[21:0] | sticky.
  - Increment when G & (S | mant[0]).
  - If the increment carries out of the mantissa, mantissa=0 and exp+1.
  - inexact = G|S.
- N2 special cases, in priority order:
  - zero: result is {sign,31'b0}, where sign = 0 for FADD/FSUB and sign_sel for FMUL.
  - exp ≥ 255 after rounding: result is {sign_sel, 8'hFF, 23'b0}, overflow=1.
  - exp ≤ 0: flush to {sign_sel, 31'b0}, underflow=1.
  - otherwise: pack normally.
- No-op op (norFALUop ≥ 3): propagates with valid, but wbfregWrite is forced to 0 and wbresult=0.
- Valid ops: wbfregWrite = norfregWrite & valid. wbfRd is passed through unchanged.
- An entry with in_valid=0 occupies its slot as a bubble; out_valid=0 for that slot.
- While out_valid=1 and out_ready=0, all wb* outputs remain stable.

Optional Feature:
- Macro: FPU_FLAGS_EN.
- Defined: wbflags is computed and registered as described in Behaviour.
- Undefined: wbflags is constant 3'b000, and no flag logic is synthesized. Results are identical in both cases.

Test Plan:
- FADD, expMAX=127, frac=48'h8000_0000_0000, signMAX=0, fRd=5, fregWrite=1, out_ready=1 -> 2 cycles later: out_valid=1, wbresult=32'h4000_0000, wbfRd=5, wbfregWrite=1.
- FMUL, expSUM=127, frac=48'h4000_0000_0000, sign=1 -> wbresult=32'hBF80_0000, flags=000.
- FSUB, expMAX=130, frac=48'h1000_0000_0000, signMAX=1 -> wbresult=32'hC000_0000.
  - Also FSUB with frac=0, signMAX=1 -> wbresult=32'h0000_0000.
- Rounding, FMUL, expSUM=127:
  - frac=48'h4000_0040_0000 -> 32'h3F80_0000, inexact=1 (tie to even).
  - frac=48'h4000_00C0_0000 -> 32'h3F80_0002.
- Boundaries:
  - FMUL, expSUM=254, frac=48'h8000_0000_0000 -> 32'h7F80_0000, overflow=1.
  - FMUL, expSUM=1, frac=48'h2000_0000_0000 -> 32'h0000_0000, underflow=1.
- Stall and reset:
  - Three back-to-back ops with out_ready held 0 once the first appears: in_ready=0, wb* held; on release, results emerge in order with no loss or duplication.
  - Assert rst with ops in flight -> out_valid=0 immediately; no stale result after reset.

Source files
------------

// File: rtl/fpu_nor_stage_if.sv
// fpu_nor_stage_if: EX/NOR pipeline-register fields in, FP writeback fields out.
// The master side is the EX/NOR register plus the writeback consumer.
// The slave side is the normalize/round stage.
interface fpu_nor_stage_if #(
    parameter int FRAC_W = 48,
    parameter int EXP_W  = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [FRAC_W-1:0] norfracALU;
    logic              norswap;
    logic              norsign;
    logic              norsignMAX;
    logic [4:0]        norFALUop;
    logic [EXP_W-1:0]  norexpSUM;
    logic [EXP_W-1:0]  norexpMAX;
    logic              norfregWrite;
    logic [4:0]        norfRd;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       wbresult;
    logic              wbfregWrite;
    logic [4:0]        wbfRd;
    logic [2:0]        wbflags;

    modport master (
        output in_valid, norfracALU, norswap, norsign, norsignMAX, norFALUop,
               norexpSUM, norexpMAX, norfregWrite, norfRd, out_ready,
        input  in_ready, out_valid, wbresult, wbfregWrite, wbfRd, wbflags
    );

    modport slave (
        input  in_valid, norfracALU, norswap, norsign, norsignMAX, norFALUop,
               norexpSUM, norexpMAX, norfregWrite, norfRd, out_ready,
        output in_ready, out_valid, wbresult, wbfregWrite, wbfRd, wbflags
    );
endinterface

// File: rtl/fpu_nor_stage.sv
// fpu_nor_stage: FPU normalize/round stage, two pipeline stages.
//   N1: leading-zero detect and normalizing shift.
//   N2: round-to-nearest-even, exponent adjust, special cases, output register.
// Both stages advance together whenever the output slot is empty or being taken.
// Optional macro FPU_FLAGS_EN: when defined, wbflags {overflow, underflow, inexact}
// is computed and registered; otherwise wbflags is tied to zero.
module fpu_nor_stage #(
    parameter int FRAC_W = 48,
    parameter int EXP_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    fpu_nor_stage_if.slave bus
);
    // Bit position of the hidden bit once the value is normalized.
    localparam int HB   = FRAC_W - 2;
    localparam int LZ_W = $clog2(FRAC_W);
    localparam int E_W  = EXP_W + 2;
    localparam logic [4:0] OP_FMUL = 5'd2;
    localparam logic [4:0] OP_NOOP = 5'd3;
    localparam logic signed [E_W-1:0] EXP_INF = E_W'((1 << EXP_W) - 1);

    logic                  w_adv;
    logic [LZ_W-1:0]       w_lz;
    logic [HB:0]           w_shl;
    logic [HB:0]           w_n1_n_d;
    logic                  w_n1_sticky_d;
    logic signed [E_W-1:0] w_exp_base;
    logic signed [E_W-1:0] w_n1_exp_d;

    logic                  r_n1_valid;
    logic [4:0]            r_n1_op;
    logic                  r_n1_sign;
    logic signed [E_W-1:0] r_n1_exp;
    logic [HB-1:0]         r_n1_n;
    logic                  r_n1_sticky;
    logic                  r_n1_zero;
    logic                  r_n1_fregw;
    logic [4:0]            r_n1_frd;

    logic [22:0]           w_mant;
    logic                  w_g;
    logic                  w_s;
    logic                  w_inc;
    logic [23:0]           w_mant_sum;
    logic signed [E_W-1:0] w_exp_rnd;
    logic                  w_ovf;
    logic                  w_unf;
    logic                  w_op_ok;
    logic [31:0]           w_result;

    logic                  r_out_valid;
    logic [31:0]           r_wbresult;
    logic                  r_wbfregw;
    logic [4:0]            r_wbfrd;

    assign w_adv        = !r_out_valid || bus.out_ready;
    assign bus.in_ready = w_adv;

    assign w_exp_base = (bus.norFALUop == OP_FMUL) ? signed'(E_W'(bus.norexpSUM))
                                                   : signed'(E_W'(bus.norexpMAX));

    // Leading zeros of frac[HB:0]; the highest set bit wins, all-zero gives HB+1.
    always_comb begin
        w_lz = LZ_W'(HB + 1);
        for (int i = 0; i <= HB; i++) begin
            if (bus.norfracALU[i]) w_lz = LZ_W'(HB - i);
        end
    end

    assign w_shl = bus.norfracALU[HB:0] << w_lz;

    // Normalize: a value in [2,4) shifts right one with sticky, otherwise shift left by lz.
    always_comb begin
        if (bus.norfracALU[FRAC_W-1]) begin
            w_n1_n_d      = bus.norfracALU[FRAC_W-1:1];
            w_n1_sticky_d = bus.norfracALU[0];
            w_n1_exp_d    = w_exp_base + E_W'(1);
        end else begin
            w_n1_n_d      = w_shl;
            w_n1_sticky_d = 1'b0;
            w_n1_exp_d    = w_exp_base - signed'(E_W'(w_lz));
        end
    end

    // N1 register; a clear hidden bit after normalization means the input was zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_n1_valid  <= 1'b0;
            r_n1_op     <= '0;
            r_n1_sign   <= 1'b0;
            r_n1_exp    <= '0;
            r_n1_n      <= '0;
            r_n1_sticky <= 1'b0;
            r_n1_zero   <= 1'b0;
            r_n1_fregw  <= 1'b0;
            r_n1_frd    <= '0;
        end else if (w_adv) begin
            r_n1_valid  <= bus.in_valid;
            r_n1_op     <= bus.norFALUop;
            r_n1_sign   <= (bus.norFALUop == OP_FMUL) ? bus.norsign : bus.norsignMAX;
            r_n1_exp    <= w_n1_exp_d;
            r_n1_n      <= w_n1_n_d[HB-1:0];
            r_n1_sticky <= w_n1_sticky_d;
            r_n1_zero   <= !w_n1_n_d[HB];
            r_n1_fregw  <= bus.norfregWrite;
            r_n1_frd    <= bus.norfRd;
        end
    end

    assign w_mant     = r_n1_n[HB-1 -: 23];
    assign w_g        = r_n1_n[HB-24];
    assign w_s        = (|r_n1_n[HB-25:0]) | r_n1_sticky;
    assign w_inc      = w_g & (w_s | w_mant[0]);
    assign w_mant_sum = {1'b0, w_mant} + {23'd0, w_inc};
    assign w_exp_rnd  = r_n1_exp + (w_mant_sum[23] ? E_W'(1) : E_W'(0));
    assign w_ovf      = (w_exp_rnd >= EXP_INF);
    assign w_unf      = (w_exp_rnd <= E_W'(0));
    assign w_op_ok    = (r_n1_op < OP_NOOP);

    // Result selection in priority order: no-op, zero, overflow, underflow, normal.
    always_comb begin
        if (!w_op_ok) begin
            w_result = '0;
        end else if (r_n1_zero) begin
            w_result = {(r_n1_op == OP_FMUL) & r_n1_sign, 31'd0};
        end else if (w_ovf) begin
            w_result = {r_n1_sign, {EXP_W{1'b1}}, 23'd0};
        end else if (w_unf) begin
            w_result = {r_n1_sign, 31'd0};
        end else begin
            w_result = {r_n1_sign, w_exp_rnd[EXP_W-1:0], w_mant_sum[22:0]};
        end
    end

    // Output register; holds while the writeback side stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_wbresult  <= '0;
            r_wbfregw   <= 1'b0;
            r_wbfrd     <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_n1_valid;
            r_wbresult  <= w_result;
            r_wbfregw   <= r_n1_fregw & r_n1_valid & w_op_ok;
            r_wbfrd     <= r_n1_frd;
        end
    end

    assign bus.out_valid   = r_out_valid;
    assign bus.wbresult    = r_wbresult;
    assign bus.wbfregWrite = r_wbfregw;
    assign bus.wbfRd       = r_wbfrd;

`ifdef FPU_FLAGS_EN
    logic [2:0] w_flags;
    logic [2:0] r_wbflags;

    // Flags only for real arithmetic results; a zero result is exact.
    always_comb begin
        if (!w_op_ok || r_n1_zero) w_flags = 3'b000;
        else                       w_flags = {w_ovf, w_unf, w_g | w_s};
    end

    // Flag register advances with the result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)        r_wbflags <= 3'b000;
        else if (w_adv) r_wbflags <= w_flags;
    end

    assign bus.wbflags = r_wbflags;
`else
    assign bus.wbflags = 3'b000;
`endif
endmodule

// File: tb/tb_fpu_nor_stage.sv
// tb_fpu_nor_stage: directed and mixed vectors against a value-level rounding
// model, plus literal expectations for the hand-computed cases.
module tb_fpu_nor_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fpu_nor_stage_if bus ();
    fpu_nor_stage dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [31:0] res;
        logic        fregw;
        logic [4:0]  frd;
        logic [2:0]  flg;
        logic        lit;
        logic [31:0] lres;
        logic [2:0]  lflg;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    exp_t nxt;
    int   errors = 0;
    int   checks = 0;

    logic        lit_on = 1'b0;
    logic [31:0] lit_res = '0;
    logic [2:0]  lit_flg = '0;
    logic        ready_force = 1'b1;
    logic        rnd_ready_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [2:0] flag_mask(input logic [2:0] f);
`ifdef FPU_FLAGS_EN
        return f;
`else
        return 3'b000 & f;
`endif
    endfunction

    // Value model: value = frac * 2^(base-127-46); round the 24-bit significand by
    // comparing the discarded remainder with one half ulp.
    function automatic exp_t model(input logic [4:0] op, input logic [47:0] frac,
                                   input logic [7:0] esum, input logic [7:0] emax,
                                   input logic sg, input logic sgm,
                                   input logic fw, input logic [4:0] rd);
        exp_t e;
        int p;
        longint ex;
        longint unsigned f, sig, rem, half;
        logic s, ov, un, ix;
        e = '0;
        e.frd = rd;
        if (op >= 5'd3) return e;
        e.fregw = fw;
        s = (op == 5'd2) ? sg : sgm;
        if (frac == 48'd0) begin
            e.res = {(op == 5'd2) ? sg : 1'b0, 31'd0};
            return e;
        end
        f = longint'(frac);
        p = 0;
        for (int i = 0; i < 48; i++) if (frac[i]) p = i;
        ex = longint'((op == 5'd2) ? esum : emax) + longint'(p) - 46;
        if (p > 23) begin
            sig  = f >> (p - 23);
            rem  = f & ((64'd1 << (p - 23)) - 64'd1);
            half = 64'd1 << (p - 24);
        end else begin
            sig  = f << (23 - p);
            rem  = 0;
            half = 1;
        end
        if (rem > half || (rem == half && sig[0])) sig = sig + 1;
        if (sig == (64'd1 << 24)) begin
            sig = sig >> 1;
            ex  = ex + 1;
        end
        ix = (rem != 0);
        ov = 1'b0;
        un = 1'b0;
        if (ex >= 255) begin
            e.res = {s, 8'hFF, 23'd0};
            ov = 1'b1;
        end else if (ex <= 0) begin
            e.res = {s, 31'd0};
            un = 1'b1;
        end else begin
            e.res = {s, 8'(ex), sig[22:0]};
        end
        e.flg = flag_mask({ov, un, ix});
        return e;
    endfunction

    // Output out_ready: forced value, or random during the mixed section.
    initial begin
        bus.out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            bus.out_ready = rnd_ready_en ? 1'($urandom_range(0, 1)) : ready_force;
        end
    end

    // Scoreboard: check the head entry whenever out_valid, record accepted inputs.
    always @(negedge clk) begin
        if (rst) begin
            q.delete();
        end else begin
            if (bus.out_valid) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_out: got out_valid=1 expected no pending result at %0t", $time);
                end else begin
                    cur = q[0];
                    chk("wbresult", bus.wbresult, cur.res);
                    chk("wbfregWrite", 32'(bus.wbfregWrite), 32'(cur.fregw));
                    chk("wbfRd", 32'(bus.wbfRd), 32'(cur.frd));
                    chk("wbflags", 32'(bus.wbflags), 32'(cur.flg));
                    if (cur.lit) begin
                        chk("lit_result", bus.wbresult, cur.lres);
                        chk("lit_flags", 32'(bus.wbflags), 32'(cur.lflg));
                    end
                    if (bus.out_ready) void'(q.pop_front());
                end
            end else begin
                chk("bubble_fregw", 32'(bus.wbfregWrite), 32'd0);
            end
            if (bus.in_valid && bus.in_ready) begin
                nxt = model(bus.norFALUop, bus.norfracALU, bus.norexpSUM, bus.norexpMAX,
                            bus.norsign, bus.norsignMAX, bus.norfregWrite, bus.norfRd);
                nxt.lit  = lit_on;
                nxt.lres = lit_res;
                nxt.lflg = flag_mask(lit_flg);
                q.push_back(nxt);
            end
        end
    end

    task automatic send(input logic [4:0] op, input logic [47:0] frac,
                        input logic [7:0] esum, input logic [7:0] emax,
                        input logic sg, input logic sgm, input logic [4:0] rd,
                        input logic fw, input logic lit, input logic [31:0] lres,
                        input logic [2:0] lflg);
        int n;
        bus.in_valid     = 1'b1;
        bus.norFALUop    = op;
        bus.norfracALU   = frac;
        bus.norexpSUM    = esum;
        bus.norexpMAX    = emax;
        bus.norsign      = sg;
        bus.norsignMAX   = sgm;
        bus.norswap      = frac[3];
        bus.norfRd       = rd;
        bus.norfregWrite = fw;
        lit_on  = lit;
        lit_res = lres;
        lit_flg = lflg;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.in_ready && n < 200);
        if (!bus.in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1 within 200 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lit_on = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || bus.out_valid) && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200us");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] r;
        logic [4:0]  rop;
        bus.in_valid = 0; bus.norFALUop = 0; bus.norfracALU = 0; bus.norexpSUM = 0;
        bus.norexpMAX = 0; bus.norsign = 0; bus.norsignMAX = 0; bus.norswap = 0;
        bus.norfRd = 0; bus.norfregWrite = 0;
        rst = 1'b1;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_wbresult", bus.wbresult, 32'd0);
        chk("rst_wbfregWrite", 32'(bus.wbfregWrite), 32'd0);
        chk("rst_wbfRd", 32'(bus.wbfRd), 32'd0);
        chk("rst_wbflags", 32'(bus.wbflags), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Latency: accepted at one edge, visible after the next.
        send(5'd0, 48'h8000_0000_0000, 8'd0, 8'd127, 1'b0, 1'b0, 5'd5, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
        chk("lat_early", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        chk("lat_valid", 32'(bus.out_valid), 32'd1);
        chk("lat_result", bus.wbresult, 32'h4000_0000);
        chk("lat_fRd", 32'(bus.wbfRd), 32'd5);
        chk("lat_fregWrite", 32'(bus.wbfregWrite), 32'd1);

        // Directed vectors, streamed back to back.
        send(5'd2, 48'h4000_0000_0000, 8'd127, 8'd0,   1'b1, 1'b0, 5'd1,  1'b1, 1'b1, 32'hBF80_0000, 3'b000);
        send(5'd1, 48'h1000_0000_0000, 8'd0,   8'd130, 1'b0, 1'b1, 5'd2,  1'b1, 1'b1, 32'hC000_0000, 3'b000);
        send(5'd1, 48'h0000_0000_0000, 8'd0,   8'd130, 1'b1, 1'b1, 5'd3,  1'b1, 1'b1, 32'h0000_0000, 3'b000);
        send(5'd2, 48'h0000_0000_0000, 8'd90,  8'd0,   1'b1, 1'b0, 5'd4,  1'b0, 1'b1, 32'h8000_0000, 3'b000);
        send(5'd2, 48'h4000_0040_0000, 8'd127, 8'd0,   1'b0, 1'b0, 5'd6,  1'b1, 1'b1, 32'h3F80_0000, 3'b001);
        send(5'd2, 48'h4000_00C0_0000, 8'd127, 8'd0,   1'b0, 1'b0, 5'd7,  1'b1, 1'b1, 32'h3F80_0002, 3'b001);
        send(5'd0, 48'h7FFF_FFC0_0000, 8'd0,   8'd127, 1'b0, 1'b0, 5'd8,  1'b1, 1'b1, 32'h4000_0000, 3'b001);
        send(5'd0, 48'h8000_0080_0001, 8'd0,   8'd127, 1'b0, 1'b0, 5'd9,  1'b1, 1'b1, 32'h4000_0001, 3'b001);
        send(5'd2, 48'h8000_0000_0000, 8'd254, 8'd0,   1'b0, 1'b0, 5'd10, 1'b1, 1'b1, 32'h7F80_0000, 3'b100);
        send(5'd2, 48'h2000_0000_0000, 8'd1,   8'd0,   1'b0, 1'b0, 5'd11, 1'b1, 1'b1, 32'h0000_0000, 3'b010);
        send(5'd5, 48'h4000_0000_0000, 8'd127, 8'd127, 1'b1, 1'b1, 5'd12, 1'b1, 1'b1, 32'h0000_0000, 3'b000);
        drain();

        // Stall: hold the first result while the third op waits.
        send(5'd2, 48'h4000_0000_0000, 8'd127, 8'd0,   1'b0, 1'b0, 5'd13, 1'b1, 1'b1, 32'h3F80_0000, 3'b000);
        send(5'd0, 48'h8000_0000_0000, 8'd0,   8'd127, 1'b0, 1'b0, 5'd14, 1'b1, 1'b1, 32'h4000_0000, 3'b000);
        ready_force = 1'b0;
        fork
            send(5'd1, 48'h1000_0000_0000, 8'd0, 8'd130, 1'b0, 1'b1, 5'd15, 1'b1, 1'b1, 32'hC000_0000, 3'b000);
            begin
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", 32'(bus.in_ready), 32'd0);
                    chk("stall_out_valid", 32'(bus.out_valid), 32'd1);
                    chk("stall_hold_result", bus.wbresult, 32'h3F80_0000);
                    chk("stall_hold_fRd", 32'(bus.wbfRd), 32'd13);
                end
                @(posedge clk);
                #1;
                ready_force = 1'b1;
            end
        join
        drain();

        // Reset with two ops in flight: nothing stale may appear afterwards.
        send(5'd2, 48'h4000_0000_0000, 8'd100, 8'd0, 1'b0, 1'b0, 5'd16, 1'b1, 1'b0, 32'd0, 3'b000);
        send(5'd2, 48'h4000_0000_0000, 8'd101, 8'd0, 1'b0, 1'b0, 5'd17, 1'b1, 1'b0, 32'd0, 3'b000);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("midrst_fregWrite", 32'(bus.wbfregWrite), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            chk("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        end

        // Mixed section: varied leading-zero counts, ops, bubbles and random out_ready.
        rnd_ready_en = 1'b1;
        for (int k = 0; k < 40; k++) begin
            r   = {$urandom, $urandom};
            rop = 5'($urandom_range(0, 4));
            send(rop, r[47:0] >> $urandom_range(0, 47), 8'($urandom_range(0, 255)),
                 8'($urandom_range(0, 255)), r[60], r[61], 5'(k), r[62], 1'b0, 32'd0, 3'b000);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rnd_ready_en = 1'b0;
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
